// File: rtl/dac_wave_gen.sv
// Phase-accumulator waveform generator feeding a DAC serializer through a
// one-entry valid/ready output register with overrun detection.
//
// state    | meaning
// ---------+---------------------------------------------------
// ST_EMPTY | no pending sample, sample_valid low
// ST_FULL  | sample_data holds a sample not yet accepted
module dac_wave_gen (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        enable,
    input  logic        tick,
    input  logic        sync_clr,
    input  logic [1:0]  wave_sel,
    input  logic [15:0] freq_word,
    input  logic [7:0]  amp_level,
    input  logic        ovr_clr,
    input  logic        sample_ready,
    output logic        sample_valid,
    output logic [7:0]  sample_data,
    output logic        overrun,
    output logic [15:0] sample_cnt
);

    typedef enum logic {ST_EMPTY, ST_FULL} state_t;

    state_t      state, state_nxt;
    logic        fire, accept, ovr_set;
    logic [15:0] phase, phase_cur, phase_nxt;
    logic [7:0]  tri_base, sample_nxt;

    assign fire         = tick & enable;
    // A sync clear takes effect for a fire in the same cycle.
    assign phase_cur    = sync_clr ? 16'h0000 : phase;
    assign sample_valid = (state == ST_FULL);
    assign accept       = sample_valid & sample_ready;
    assign ovr_set      = fire & sample_valid & ~sample_ready;
    assign tri_base     = {phase_cur[14:8], 1'b0};

    always_comb begin
        sample_nxt = 8'h00;
        case (wave_sel)
            2'b00: sample_nxt = phase_cur[15:8];
            2'b01: sample_nxt = phase_cur[15] ? ~tri_base : tri_base;
            2'b10: sample_nxt = phase_cur[15] ? 8'h00 : amp_level;
            2'b11: sample_nxt = amp_level;
            default: sample_nxt = 8'h00;
        endcase
    end

    always_comb begin
        phase_nxt = phase;
        if (fire)
            phase_nxt = phase_cur + freq_word;
        else if (sync_clr)
            phase_nxt = 16'h0000;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_EMPTY: if (fire) state_nxt = ST_FULL;
            ST_FULL:  if (!fire && sample_ready) state_nxt = ST_EMPTY;
            default:  state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state <= ST_EMPTY;
            phase <= 16'h0000;
        end else begin
            state <= state_nxt;
            phase <= phase_nxt;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sample_data <= 8'h00;
            overrun     <= 1'b0;
            sample_cnt  <= 16'h0000;
        end else begin
            if (fire)
                sample_data <= sample_nxt;
            // Set wins over a simultaneous clear.
            if (ovr_set)
                overrun <= 1'b1;
            else if (ovr_clr)
                overrun <= 1'b0;
            if (accept)
                sample_cnt <= sample_cnt + 16'h0001;
        end
    end

endmodule
